// File: rtl/layer_priority_ctrl_pkg.sv
// Shared types for the VGA layer priority controller: layer indices, masks,
// configuration FSM states and the blink phase.
package layer_priority_ctrl_pkg;

    typedef enum logic [1:0] {
        LAYER_BALL  = 2'd0,
        LAYER_HOLE2 = 2'd1,
        LAYER_HOLE1 = 2'd2,
        LAYER_HART  = 2'd3
    } layer_idx_t;

    typedef logic [3:0] layer_mask_t;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_PENDING,
        CFG_COMMIT
    } cfg_state_t;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blink_phase_t;

    localparam int HOLE2_BIT = 1;

    // Blink can only hide the hole2 layer, never reveal one that config disabled.
    function automatic layer_mask_t apply_blink(input layer_mask_t en,
                                                input logic active,
                                                input blink_phase_t phase);
        layer_mask_t m;
        m = en;
        if (active && phase == PHASE_OFF)
            m[HOLE2_BIT] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/layer_priority_ctrl_blink_timer.sv
// Frame-counted blink sequencer: runs for BLINK_FRAMES frames, toggling the
// phase every BLINK_PERIOD frames; a restart pulse begins again from frame 0.
module frame_blink_timer
    import layer_priority_ctrl_pkg::*;
#(
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_of_frame,
    input  logic         restart,
    output logic         active,
    output blink_phase_t phase
);

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int PW = $clog2(BLINK_PERIOD + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(BLINK_PERIOD - 1);

    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] phase_cnt;

    // Restart takes priority over a coincident frame start, so that frame is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            phase     <= PHASE_OFF;
            frame_cnt <= '0;
            phase_cnt <= '0;
        end else if (restart) begin
            active    <= 1'b1;
            phase     <= PHASE_OFF;
            frame_cnt <= '0;
            phase_cnt <= '0;
        end else if (active && start_of_frame) begin
            if (frame_cnt == LAST_FRAME) begin
                active    <= 1'b0;
                phase     <= PHASE_OFF;
                frame_cnt <= '0;
                phase_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
                if (phase_cnt == LAST_PHASE) begin
                    phase_cnt <= '0;
                    phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
                end else begin
                    phase_cnt <= phase_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Layer configuration sequencer for the VGA object mux: buffers game-logic
// updates and commits them at frame start, and overlays the hole blink.
module layer_priority_ctrl
    import layer_priority_ctrl_pkg::*;
#(
    parameter layer_mask_t RESET_EN     = 4'b0111,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       cfg_req,
    input  logic [3:0] cfg_en,
    input  logic [1:0] cfg_top,
    output logic       cfg_busy,
    output logic       cfg_ack,
    input  logic       hole_event,
    output logic [3:0] layer_en,
    output logic [1:0] top_sel,
    output logic       blink_active
);

    cfg_state_t   state;
    cfg_state_t   next_state;
    layer_mask_t  shadow_en;
    layer_idx_t   shadow_top;
    layer_mask_t  committed_en;
    layer_idx_t   committed_top;
    blink_phase_t blink_phase;

    // Shadow is written only on the IDLE accept; committed regs only in COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CFG_IDLE;
            shadow_en     <= '0;
            shadow_top    <= LAYER_BALL;
            committed_en  <= RESET_EN;
            committed_top <= LAYER_BALL;
        end else begin
            state <= next_state;
            if (state == CFG_IDLE && cfg_req) begin
                shadow_en  <= cfg_en;
                shadow_top <= layer_idx_t'(cfg_top);
            end
            if (state == CFG_COMMIT) begin
                committed_en  <= shadow_en;
                committed_top <= shadow_top;
            end
        end
    end

    always_comb begin
        next_state = state;
        cfg_busy   = 1'b0;
        cfg_ack    = 1'b0;
        case (state)
            CFG_IDLE: begin
                if (cfg_req)
                    next_state = CFG_PENDING;
            end
            CFG_PENDING: begin
                cfg_busy = 1'b1;
                if (startOfFrame)
                    next_state = CFG_COMMIT;
            end
            CFG_COMMIT: begin
                cfg_busy   = 1'b1;
                cfg_ack    = 1'b1;
                next_state = CFG_IDLE;
            end
            default: next_state = CFG_IDLE;
        endcase
    end

    frame_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES),
        .BLINK_PERIOD(BLINK_PERIOD)
    ) u_blink (
        .clk           (clk),
        .reset         (reset),
        .start_of_frame(startOfFrame),
        .restart       (hole_event),
        .active        (blink_active),
        .phase         (blink_phase)
    );

    assign layer_en = apply_blink(committed_en, blink_active, blink_phase);
    assign top_sel  = committed_top;

endmodule
